// File: rtl/csa_pipe_adder_if.sv
// rtl/csa_pipe_adder_if.sv - operand/result handshake bundle for csa_pipe_adder
interface csa_pipe_adder_if #(
  parameter int WIDTH = 44
) ();
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;

  // Issuer / result consumer side
  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf
  );

  // Adder side
  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor with valid/ready flow control
module csa_pipe_adder #(
  parameter int WIDTH  = 44,
  parameter int BLOCK  = 4,
  parameter int STAGES = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  csa_pipe_adder_if.slave bus
);
  localparam int NSEG = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int SPS  = (NSEG + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage k registers: operands (A, B'), sum bits resolved so far, carry out of
  // the highest resolved segment, and the valid bit. Bits of A/B' already
  // consumed are dead downstream except the MSBs that feed o_ovf.
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  logic [WIDTH-1:0]  w_a_nxt [STAGES];
  logic [WIDTH-1:0]  w_b_nxt [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [STAGES-1:0] w_c_nxt;
  logic [STAGES-1:0] w_v_nxt;

  logic [WIDTH-1:0]  w_b_in;
  logic              w_c0;
  logic              w_adv;

  assign w_b_in = bus.i_add_term2 ^ {WIDTH{bus.i_sub}};
  assign w_c0   = bus.i_sub ? 1'b1 : bus.i_cin;

  // Single global advance: the whole pipe moves unless the output is held
  assign w_adv       = !r_v[LAST] || bus.i_ready;
  assign bus.o_ready = w_adv;

  assign bus.o_valid = r_v[LAST];
  assign bus.o_sum   = r_s[LAST];
  assign bus.o_cout  = r_c[LAST];
  assign bus.o_ovf   = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &&
                       (r_s[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

  // Next state of every stage: resolve this stage's segments on top of the predecessor's registers
  always_comb begin
    int               p;
    int               lo;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             c_0;
    logic             c_1;
    logic [BLOCK-1:0] t_0;
    logic [BLOCK-1:0] t_1;
    p       = 0;
    lo      = 0;
    a       = '0;
    b       = '0;
    s       = '0;
    c       = 1'b0;
    c_0     = 1'b0;
    c_1     = 1'b0;
    t_0     = '0;
    t_1     = '0;
    w_a_nxt = '{default: '0};
    w_b_nxt = '{default: '0};
    w_s_nxt = '{default: '0};
    w_c_nxt = '0;
    w_v_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        a = bus.i_add_term1;
        b = w_b_in;
        s = '0;
        c = w_c0;
      end else begin
        a = r_a[p];
        b = r_b[p];
        s = r_s[p];
        c = r_c[p];
      end
      // Stages past the last segment fall through as pure delay
      for (int j = 0; j < NSEG; j++) begin
        if (j >= k * SPS && j < (k + 1) * SPS) begin
          lo  = j * BLOCK;
          // Segment 0 ripples with the true carry-in; the others precompute both carries
          c_0 = (j == 0) ? c : 1'b0;
          c_1 = 1'b1;
          t_0 = '0;
          t_1 = '0;
          for (int i = 0; i < BLOCK; i++) begin
            if (lo + i < WIDTH) begin
              t_0[i] = a[lo+i] ^ b[lo+i] ^ c_0;
              t_1[i] = a[lo+i] ^ b[lo+i] ^ c_1;
              c_0    = (a[lo+i] & b[lo+i]) | (c_0 & (a[lo+i] ^ b[lo+i]));
              c_1    = (a[lo+i] & b[lo+i]) | (c_1 & (a[lo+i] ^ b[lo+i]));
            end
          end
          if (j != 0 && c) begin
            for (int i = 0; i < BLOCK; i++) begin
              if (lo + i < WIDTH) s[lo+i] = t_1[i];
            end
            c = c_1;
          end else begin
            for (int i = 0; i < BLOCK; i++) begin
              if (lo + i < WIDTH) s[lo+i] = t_0[i];
            end
            c = c_0;
          end
        end
      end
      w_a_nxt[k] = a;
      w_b_nxt[k] = b;
      w_s_nxt[k] = s;
      w_c_nxt[k] = c;
      w_v_nxt[k] = (k == 0) ? bus.i_valid : r_v[p];
    end
  end

  // Pipeline registers: clear on reset, all stages load together on advance, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '{default: '0};
      r_b <= '{default: '0};
      r_s <= '{default: '0};
      r_c <= '0;
      r_v <= '0;
    end else if (w_adv) begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      r_s <= w_s_nxt;
      r_c <= w_c_nxt;
      r_v <= w_v_nxt;
    end
  end
endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder
module tb_csa_pipe_adder;
  localparam int S44 = 3;
  localparam int S10 = 2;

  logic clk = 1'b0;
  logic rst44_n;
  logic rst10_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(44)) b44 ();
  csa_pipe_adder_if #(.WIDTH(10)) b10 ();

  csa_pipe_adder #(.WIDTH(44), .BLOCK(4), .STAGES(S44)) dut44 (
    .i_clk(clk), .i_rst_n(rst44_n), .bus(b44)
  );
  csa_pipe_adder #(.WIDTH(10), .BLOCK(4), .STAGES(S10)) dut10 (
    .i_clk(clk), .i_rst_n(rst10_n), .bus(b10)
  );

  // Reference: plain integer arithmetic, {ovf, cout, sum}
  function automatic logic [65:0] ref_op(input longint unsigned a, input longint unsigned b,
                                         input logic cin, input logic sub, input int w);
    longint unsigned mask, sum, lim;
    longint          sa, sb, t;
    logic            cout, ovf;
    mask = (64'd1 << w) - 64'd1;
    if (sub) begin
      sum  = (a - b) & mask;
      cout = (a >= b);
    end else begin
      sum  = (a + b + 64'(cin)) & mask;
      cout = ((a + b + 64'(cin)) >> w) != 64'd0;
    end
    lim = 64'd1 << (w - 1);
    sa  = (a >= lim) ? longint'(a) - 2 * longint'(lim) : longint'(a);
    sb  = (b >= lim) ? longint'(b) - 2 * longint'(lim) : longint'(b);
    t   = sub ? sa - sb : sa + sb + longint'(64'(cin));
    ovf = (t >= longint'(lim)) || (t < -longint'(lim));
    return {ovf, cout, sum};
  endfunction

  function automatic logic [43:0] rnd44();
    logic [63:0] r;
    int          sel;
    r   = {$urandom(), $urandom()};
    sel = $urandom_range(7);
    if (sel == 0) r = '0;
    else if (sel == 1) r = '1;
    else if (sel == 2) r = 64'h7FFFFFFFFFF;
    else if (sel == 3) r = 64'h80000000000;
    return r[43:0];
  endfunction

  function automatic logic [9:0] rnd10();
    logic [31:0] r;
    r = $urandom_range(1023);
    return r[9:0];
  endfunction

  task automatic drain44();
    b44.i_valid = 1'b0;
    b44.i_ready = 1'b1;
    repeat (S44 + 1) @(negedge clk);
  endtask

  task automatic drain10();
    b10.i_valid = 1'b0;
    b10.i_ready = 1'b1;
    repeat (S10 + 1) @(negedge clk);
  endtask

  task automatic op44(input logic [43:0] a, input logic [43:0] b, input logic cin, input logic sub,
                      output logic [43:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    b44.i_add_term1 = a;
    b44.i_add_term2 = b;
    b44.i_cin       = cin;
    b44.i_sub       = sub;
    b44.i_valid     = 1'b1;
    b44.i_ready     = 1'b1;
    @(posedge clk);
    #1;
    b44.i_valid = 1'b0;
    lat = 0;
    while (b44.o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = b44.o_sum;
    co = b44.o_cout;
    ov = b44.o_ovf;
  endtask

  task automatic op10(input logic [9:0] a, input logic [9:0] b, input logic cin, input logic sub,
                      output logic [9:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    b10.i_add_term1 = a;
    b10.i_add_term2 = b;
    b10.i_cin       = cin;
    b10.i_sub       = sub;
    b10.i_valid     = 1'b1;
    b10.i_ready     = 1'b1;
    @(posedge clk);
    #1;
    b10.i_valid = 1'b0;
    lat = 0;
    while (b10.o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = b10.o_sum;
    co = b10.o_cout;
    ov = b10.o_ovf;
  endtask

  task automatic test_reset();
    rst44_n = 1'b0;
    rst10_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      b44.i_valid = 1'b1; b44.i_ready = 1'($urandom_range(1));
      b44.i_add_term1 = rnd44(); b44.i_add_term2 = rnd44();
      b44.i_cin = 1'($urandom_range(1)); b44.i_sub = 1'($urandom_range(1));
      b10.i_valid = 1'b1; b10.i_ready = 1'($urandom_range(1));
      b10.i_add_term1 = rnd10(); b10.i_add_term2 = rnd10();
      b10.i_cin = 1'($urandom_range(1)); b10.i_sub = 1'($urandom_range(1));
    end
    #1;
    n_checks++; if (b44.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_o_valid: got %b expected 0", b44.o_valid); end
    n_checks++; if (b44.o_sum !== 44'h0) begin n_errors++; $display("FAIL reset_o_sum: got %h expected 0", b44.o_sum); end
    n_checks++; if (b44.o_cout !== 1'b0) begin n_errors++; $display("FAIL reset_o_cout: got %b expected 0", b44.o_cout); end
    n_checks++; if (b44.o_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_o_ovf: got %b expected 0", b44.o_ovf); end
    n_checks++; if (b10.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_o_valid10: got %b expected 0", b10.o_valid); end
    @(negedge clk);
    rst44_n = 1'b1;
    rst10_n = 1'b1;
    b44.i_valid = 1'b0; b44.i_ready = 1'b1;
    b10.i_valid = 1'b0; b10.i_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (b44.o_ready !== 1'b1) begin n_errors++; $display("FAIL reset_o_ready: got %b expected 1", b44.o_ready); end
    n_checks++; if (b10.o_ready !== 1'b1) begin n_errors++; $display("FAIL reset_o_ready10: got %b expected 1", b10.o_ready); end
  endtask

  task automatic test_carry_chain();
    logic [43:0] s; logic co, ov; int lat;
    op44(44'hFFFFFFFFFFF, 44'h001, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (s !== 44'h0) begin n_errors++; $display("FAIL carry_sum: got %h expected 00000000000", s); end
    n_checks++; if (co !== 1'b1) begin n_errors++; $display("FAIL carry_cout: got %b expected 1", co); end
    n_checks++; if (ov !== 1'b0) begin n_errors++; $display("FAIL carry_ovf: got %b expected 0", ov); end
    n_checks++; if (lat != S44 - 1) begin n_errors++; $display("FAIL carry_latency: got %0d expected %0d", lat, S44 - 1); end
  endtask

  task automatic test_subtract();
    logic [43:0] s; logic co, ov; int lat;
    op44(44'h005, 44'h007, 1'b1, 1'b1, s, co, ov, lat);
    n_checks++; if (s !== 44'hFFFFFFFFFFE) begin n_errors++; $display("FAIL sub_sum: got %h expected FFFFFFFFFFE", s); end
    n_checks++; if (co !== 1'b0) begin n_errors++; $display("FAIL sub_cout: got %b expected 0", co); end
    n_checks++; if (ov !== 1'b0) begin n_errors++; $display("FAIL sub_ovf: got %b expected 0", ov); end
  endtask

  task automatic test_overflow();
    logic [43:0] s; logic co, ov; int lat;
    op44(44'h7FFFFFFFFFF, 44'h001, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (s !== 44'h80000000000) begin n_errors++; $display("FAIL ovf_sum: got %h expected 80000000000", s); end
    n_checks++; if (co !== 1'b0) begin n_errors++; $display("FAIL ovf_cout: got %b expected 0", co); end
    n_checks++; if (ov !== 1'b1) begin n_errors++; $display("FAIL ovf_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_random_ops();
    logic [43:0] a, b, s; logic cin, sub, co, ov; int lat;
    logic [65:0] exp;
    for (int n = 0; n < 24; n++) begin
      a = rnd44(); b = rnd44();
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      exp = ref_op(64'(a), 64'(b), cin, sub, 44);
      op44(a, b, cin, sub, s, co, ov, lat);
      n_checks++;
      if ({ov, co, 20'd0, s} !== exp) begin
        n_errors++;
        $display("FAIL random_op a=%h b=%h cin=%b sub=%b: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                 a, b, cin, sub, ov, co, s, exp[65], exp[64], exp[43:0]);
      end
    end
  endtask

  task automatic test_stream(input string name, input int n, input int ready_pct);
    logic [65:0] exp_q[$];
    logic [65:0] exp, got_v, held;
    logic [43:0] a, b;
    logic        cin, sub, stalled, extra;
    int          issued, got, cyc;
    issued = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    drain44();
    while (got < n && cyc < 1000) begin
      @(negedge clk);
      b44.i_ready = ($urandom_range(99) < ready_pct);
      #1;
      got_v = {b44.o_ovf, b44.o_cout, 20'd0, b44.o_sum};
      if (stalled) begin
        n_checks++;
        if (b44.o_valid !== 1'b1 || got_v !== held) begin
          n_errors++;
          $display("FAIL %s_stall_hold: got valid=%b out=%h expected valid=1 out=%h", name, b44.o_valid, got_v, held);
        end
      end
      if (b44.o_valid === 1'b1 && b44.i_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL %s_extra_result: got out=%h expected no result", name, got_v);
        end else begin
          exp = exp_q.pop_front();
          if (got_v !== exp) begin
            n_errors++;
            $display("FAIL %s_result_%0d: got %h expected %h", name, got, got_v, exp);
          end
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = (b44.o_valid === 1'b1);
        held    = got_v;
      end
      if (issued < n && b44.o_ready === 1'b1) begin
        a = rnd44(); b = rnd44();
        cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
        b44.i_add_term1 = a; b44.i_add_term2 = b; b44.i_cin = cin; b44.i_sub = sub;
        b44.i_valid = 1'b1;
        exp_q.push_back(ref_op(64'(a), 64'(b), cin, sub, 44));
        issued++;
      end else begin
        b44.i_valid = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    b44.i_valid = 1'b0;
    b44.i_ready = 1'b1;
    n_checks++;
    if (got != n) begin n_errors++; $display("FAIL %s_count: got %0d results expected %0d", name, got, n); end
    if (ready_pct == 100) begin
      n_checks++;
      if (cyc != n + S44) begin n_errors++; $display("FAIL %s_throughput: got %0d cycles expected %0d", name, cyc, n + S44); end
    end
    extra = 1'b0;
    repeat (S44 + 2) begin
      @(posedge clk);
      #1;
      if (b44.o_valid === 1'b1) extra = 1'b1;
    end
    n_checks++;
    if (extra !== 1'b0) begin n_errors++; $display("FAIL %s_duplicate: got o_valid=%b after drain expected 0", name, extra); end
  endtask

  task automatic test_partial();
    logic [9:0] a, b, s; logic cin, sub, co, ov; int lat;
    logic [65:0] exp;
    drain10();
    op10(10'h3FF, 10'h001, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (s !== 10'h000) begin n_errors++; $display("FAIL partial_sum: got %h expected 000", s); end
    n_checks++; if (co !== 1'b1) begin n_errors++; $display("FAIL partial_cout: got %b expected 1", co); end
    n_checks++; if (lat != S10 - 1) begin n_errors++; $display("FAIL partial_latency: got %0d expected %0d", lat, S10 - 1); end
    for (int n = 0; n < 12; n++) begin
      a = rnd10(); b = rnd10();
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      exp = ref_op(64'(a), 64'(b), cin, sub, 10);
      op10(a, b, cin, sub, s, co, ov, lat);
      n_checks++;
      if ({ov, co, 54'd0, s} !== exp) begin
        n_errors++;
        $display("FAIL partial_random a=%h b=%h cin=%b sub=%b: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                 a, b, cin, sub, ov, co, s, exp[65], exp[64], exp[9:0]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [9:0] s; logic co, ov, seen; int lat;
    drain10();
    @(negedge clk);
    b10.i_ready = 1'b0;
    b10.i_add_term1 = 10'h0F0; b10.i_add_term2 = 10'h00F; b10.i_cin = 1'b0; b10.i_sub = 1'b0;
    b10.i_valid = 1'b1;
    @(negedge clk);
    b10.i_add_term1 = 10'h123; b10.i_add_term2 = 10'h011;
    @(negedge clk);
    b10.i_valid = 1'b0;
    #1;
    n_checks++; if (b10.o_valid !== 1'b1) begin n_errors++; $display("FAIL inflight_held: got o_valid=%b expected 1", b10.o_valid); end
    rst10_n = 1'b0;
    #1;
    n_checks++; if (b10.o_valid !== 1'b0) begin n_errors++; $display("FAIL inflight_async_clear: got o_valid=%b expected 0", b10.o_valid); end
    @(negedge clk);
    rst10_n = 1'b1;
    b10.i_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (b10.o_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL inflight_discarded: got o_valid=%b after release expected 0", seen); end
    op10(10'h155, 10'h0AA, 1'b0, 1'b0, s, co, ov, lat);
    n_checks++; if (s !== 10'h1FF) begin n_errors++; $display("FAIL post_reset_sum: got %h expected 1FF", s); end
    n_checks++; if (co !== 1'b0) begin n_errors++; $display("FAIL post_reset_cout: got %b expected 0", co); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    b44.i_valid = 1'b0; b44.i_ready = 1'b1; b44.i_add_term1 = '0; b44.i_add_term2 = '0;
    b44.i_cin = 1'b0; b44.i_sub = 1'b0;
    b10.i_valid = 1'b0; b10.i_ready = 1'b1; b10.i_add_term1 = '0; b10.i_add_term2 = '0;
    b10.i_cin = 1'b0; b10.i_sub = 1'b0;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_overflow();
    test_random_ops();
    test_stream("backpressure", 8, 50);
    test_stream("back_to_back", 16, 100);
    test_partial();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
